// File: rtl/paralle_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paralle_bus_pkg
// Purpose  : Shared definitions for the asynchronous parallel bus
//            (10-bit address, 8-bit data) between paralle_master and
//            paralle_slave.
// Contents : bus widths, slave base address and register offset, master
//            state encoding, helper for sizing the phase counter.
// Revision : 1.0 - initial release
// ============================================================================
package paralle_bus_pkg;

  localparam int BUS_ADDR_W = 10;
  localparam int BUS_DATA_W = 8;

  // Slave block decodes ADR[9:4]; the setup register sits at offset 0.
  localparam logic [5:0] SLAVE_BASE    = 6'b000101;
  localparam logic [3:0] REG_SETUP_OFS = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/paralle_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : paralle_phase_timer
// Purpose  : Loadable down-counter timing the SETUP, STROBE and HOLD phases.
//            Loaded with the phase length on entry; expire is high during the
//            final cycle of the phase (count == 1).
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            load     - load load_val into the counter this edge
//            load_val - phase length in cycles (>= 1)
//            expire   - last cycle of the current phase
// Revision : 1.0 - initial release
// ============================================================================
module paralle_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      // Parks at zero once the final phase ends, so expire stays low in IDLE.
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign expire = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/paralle_master.sv
`default_nettype none
// ============================================================================
// Module   : paralle_master
// Purpose  : Bus master for the asynchronous parallel bus. Turns single-word
//            read/write commands into ADR/Data plus active-low BWR/BRD strobes
//            with programmable setup, pulse and hold times (in CLK cycles),
//            and returns captured read data.
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            start/rw/addr/wdata - command request (sampled only in IDLE)
//            busy, done, rdata   - command status and read result
//            ADR, Data, BWR, BRD - external bus
// Revision : 1.0 - initial release
// ============================================================================
module paralle_master
  import paralle_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [DATA_W-1:0] Data,
  output logic              BWR,
  output logic              BRD
);

  localparam int CNT_W = $clog2(max3(T_SETUP, T_PULSE, T_HOLD)) + 1;

  bus_state_t        r_state;
  logic              r_cmd_rw;
  logic [DATA_W-1:0] r_wdata;
  logic              r_data_oe;

  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_tmr_expire;

  // The timer is reloaded on every state entry except the return to IDLE.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(T_SETUP);
        end
      end
      SETUP: begin
        if (w_tmr_expire) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(T_PULSE);
        end
      end
      STROBE: begin
        if (w_tmr_expire) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(T_HOLD);
        end
      end
      default: begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
      end
    endcase
  end

  paralle_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expire   (w_tmr_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cmd_rw  <= 1'b0;
      r_wdata   <= '0;
      r_data_oe <= 1'b0;
      ADR       <= '0;
      BWR       <= 1'b1;
      BRD       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cmd_rw  <= rw;
            r_wdata   <= wdata;
            ADR       <= addr;
            // Data is only ever enabled for writes, so a read strobe can
            // never see the master driving the bus.
            r_data_oe <= ~rw;
            busy      <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_tmr_expire) begin
            BWR     <= r_cmd_rw;
            BRD     <= ~r_cmd_rw;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          if (w_tmr_expire) begin
            BWR <= 1'b1;
            BRD <= 1'b1;
            // Sampled on the same edge that releases BRD, while the slave
            // is still driving.
            if (r_cmd_rw) begin
              rdata <= Data;
            end
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_tmr_expire) begin
            r_data_oe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Data = r_data_oe ? r_wdata : 'z;

endmodule
`default_nettype wire
